taxi_dma_ram_seg_psdp: RTL and testbench

- Segmented simple-dual-port DMA RAM: one write-command port and one read-command/response port, SEGS independent segments.
- Sits directly downstream of the DMA RAM write demux (and the matching read demux). It terminates the write commands they issue and produces the per-command write-done pulses the demux reorders.
- Serves as the standard packet/descriptor buffer behind DMA interface blocks.

---
 rtl/taxi_dma_ram_seg_psdp.sv | 123 ++++++++++++
 tb/tb_taxi_dma_ram_seg_psdp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_dma_ram_seg_psdp.sv
// rtl/taxi_dma_ram_seg_psdp.sv - segmented simple-dual-port DMA RAM
// Independent per-segment arrays with a byte-enable write port and an elastic read pipeline.
module taxi_dma_ram_seg_psdp #(
    parameter int SIZE       = 4096,
    parameter int SEGS       = 2,
    parameter int SEG_DATA_W = 128,
    parameter int SEG_BE_W   = SEG_DATA_W / 8,
    parameter int SEG_ADDR_W = $clog2(SIZE / (SEGS * SEG_BE_W)),
    parameter int PIPELINE   = 2
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [SEGS*SEG_BE_W-1:0]       wr_cmd_be,
    input  logic [SEGS*SEG_ADDR_W-1:0]     wr_cmd_addr,
    input  logic [SEGS*SEG_DATA_W-1:0]     wr_cmd_data,
    input  logic [SEGS-1:0]                wr_cmd_valid,
    output logic [SEGS-1:0]                wr_cmd_ready,
    output logic [SEGS-1:0]                wr_done,

    input  logic [SEGS*SEG_ADDR_W-1:0]     rd_cmd_addr,
    input  logic [SEGS-1:0]                rd_cmd_valid,
    output logic [SEGS-1:0]                rd_cmd_ready,
    output logic [SEGS*SEG_DATA_W-1:0]     rd_resp_data,
    output logic [SEGS-1:0]                rd_resp_valid,
    input  logic [SEGS-1:0]                rd_resp_ready
);

    generate
        if (SIZE <= 0 || (SIZE & (SIZE - 1)) != 0) begin : g_err_size_pow2
            $error("SIZE must be a power of two");
        end
        if (SIZE < SEGS * SEG_BE_W) begin : g_err_size_min
            $error("SIZE must be at least SEGS*SEG_BE_W");
        end
        if (SEGS <= 0 || (SEGS & (SEGS - 1)) != 0) begin : g_err_segs
            $error("SEGS must be a power of two");
        end
        if (PIPELINE < 1) begin : g_err_pipeline
            $error("PIPELINE must be at least 1");
        end
    endgenerate

    // Writes are never refused, even while in reset.
    assign wr_cmd_ready = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_done <= '0;
        end else begin
            wr_done <= wr_cmd_valid;
        end
    end

    for (genvar n = 0; n < SEGS; n++) begin : g_seg
        logic [SEG_DATA_W-1:0] mem [2**SEG_ADDR_W];

        logic [SEG_ADDR_W-1:0] wr_addr;
        logic [SEG_BE_W-1:0]   wr_be;
        logic [SEG_DATA_W-1:0] wr_data;
        logic [SEG_ADDR_W-1:0] rd_addr;

        logic [PIPELINE-1:0]   stage_valid;
        logic [SEG_DATA_W-1:0] stage_data [PIPELINE];
        logic [PIPELINE-1:0]   adv;

        assign wr_addr = wr_cmd_addr[n*SEG_ADDR_W +: SEG_ADDR_W];
        assign wr_be   = wr_cmd_be[n*SEG_BE_W +: SEG_BE_W];
        assign wr_data = wr_cmd_data[n*SEG_DATA_W +: SEG_DATA_W];
        assign rd_addr = rd_cmd_addr[n*SEG_ADDR_W +: SEG_ADDR_W];

        always_ff @(posedge clk) begin
            if (wr_cmd_valid[n]) begin
                for (int b = 0; b < SEG_BE_W; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end

        // A stage may load when it is empty or the stage after it is loading.
        always_comb begin
            adv = '0;
            adv[PIPELINE-1] = !stage_valid[PIPELINE-1] || rd_resp_ready[n];
            for (int k = PIPELINE - 2; k >= 0; k--) begin
                adv[k] = !stage_valid[k] || adv[k+1];
            end
        end

        // Stage 0 is the RAM output register; reading old contents gives read-first collisions.
        always_ff @(posedge clk) begin
            if (adv[0]) begin
                stage_data[0] <= mem[rd_addr];
            end
            for (int k = 1; k < PIPELINE; k++) begin
                if (adv[k]) begin
                    stage_data[k] <= stage_data[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid <= '0;
            end else begin
                if (adv[0]) begin
                    stage_valid[0] <= rd_cmd_valid[n];
                end
                for (int k = 1; k < PIPELINE; k++) begin
                    if (adv[k]) begin
                        stage_valid[k] <= stage_valid[k-1];
                    end
                end
            end
        end

        assign rd_cmd_ready[n]                          = adv[0];
        assign rd_resp_valid[n]                         = stage_valid[PIPELINE-1];
        assign rd_resp_data[n*SEG_DATA_W +: SEG_DATA_W] = stage_data[PIPELINE-1];
    end

endmodule

// File: tb/tb_taxi_dma_ram_seg_psdp.sv
// tb/tb_taxi_dma_ram_seg_psdp.sv - directed self-checking bench for taxi_dma_ram_seg_psdp
module tb_taxi_dma_ram_seg_psdp;

    localparam int AW = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wr_cmd_be;
    logic [13:0]  wr_cmd_addr;
    logic [255:0] wr_cmd_data;
    logic [1:0]   wr_cmd_valid;
    logic [1:0]   wr_cmd_ready;
    logic [1:0]   wr_done;
    logic [13:0]  rd_cmd_addr;
    logic [1:0]   rd_cmd_valid;
    logic [1:0]   rd_cmd_ready;
    logic [255:0] rd_resp_data;
    logic [1:0]   rd_resp_valid;
    logic [1:0]   rd_resp_ready;

    int n_assert = 0;
    int n_fail   = 0;

    taxi_dma_ram_seg_psdp dut (
        .clk           (clk),
        .rst           (rst),
        .wr_cmd_be     (wr_cmd_be),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_data   (wr_cmd_data),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_done       (wr_done),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_resp_data  (rd_resp_data),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk0(input int i);
        return {16{8'(i + 64)}};
    endfunction

    function automatic logic [127:0] mk1(input int i);
        return {8{16'(i * 257 + 16'h1234)}};
    endfunction

    task automatic idle();
        wr_cmd_valid = '0;
        rd_cmd_valid = '0;
    endtask

    task automatic set_wr(input int seg, input int addr, input logic [127:0] data, input logic [15:0] be);
        wr_cmd_valid[seg]            = 1'b1;
        wr_cmd_addr[seg*AW +: AW]    = AW'(addr);
        wr_cmd_data[seg*128 +: 128]  = data;
        wr_cmd_be[seg*16 +: 16]      = be;
    endtask

    task automatic set_rd(input int seg, input int addr);
        rd_cmd_valid[seg]         = 1'b1;
        rd_cmd_addr[seg*AW +: AW] = AW'(addr);
    endtask

    // Single read into an empty pipeline with rd_resp_ready high: response visible two cycles later.
    task automatic read_chk(input int seg, input int addr, input logic [127:0] exp, input string tag);
        @(negedge clk);
        idle();
        set_rd(seg, addr);
        @(negedge clk);
        idle();
        check({tag, "_early"}, 128'(rd_resp_valid[seg]), 128'd0);
        @(negedge clk);
        check({tag, "_valid"}, 128'(rd_resp_valid[seg]), 128'd1);
        check(tag, rd_resp_data[seg*128 +: 128], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int sent, rcv, in_flight, cyc;
    logic held;
    logic [127:0] held_data;
    logic exp_ready;

    initial begin
        rst           = 1'b1;
        wr_cmd_be     = '0;
        wr_cmd_addr   = '0;
        wr_cmd_data   = '0;
        wr_cmd_valid  = '0;
        rd_cmd_addr   = '0;
        rd_cmd_valid  = '0;
        rd_resp_ready = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 128'(rd_resp_valid), 128'd0);
        check("rst_wr_done", 128'(wr_done), 128'd0);
        check("rst_rd_cmd_ready", 128'(rd_cmd_ready), 128'd3);
        check("rst_wr_cmd_ready", 128'(wr_cmd_ready), 128'd3);

        // Test 1: full write then partial byte-enable overwrite
        @(negedge clk);
        set_wr(0, 5, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF);
        @(negedge clk);
        check("t1_done_a", 128'(wr_done), 128'd1);
        idle();
        set_wr(0, 5, {16{8'hAA}}, 16'h00F0);
        @(negedge clk);
        check("t1_done_b", 128'(wr_done), 128'd1);
        idle();
        @(negedge clk);
        check("t1_done_end", 128'(wr_done), 128'd0);
        read_chk(0, 5, 128'h0F0E0D0C0B0A0908AAAAAAAA03020100, "t1_read");

        // Test 2: 16 back-to-back seg1 writes, the last with be == 0 onto addr 3
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) check("t2_done", 128'(wr_done), 128'd2);
            idle();
            if (i == 15) set_wr(1, 3, '1, 16'h0000);
            else         set_wr(1, i, mk1(i), 16'hFFFF);
        end
        @(negedge clk);
        check("t2_done_last", 128'(wr_done), 128'd2);
        idle();
        @(negedge clk);
        check("t2_done_end", 128'(wr_done), 128'd0);
        read_chk(1, 3, mk1(3), "t2_be0_read");

        // Test 3: preload seg0, then stream 32 reads with no backpressure
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idle();
            set_wr(0, i, mk0(i), 16'hFFFF);
        end
        @(negedge clk);
        idle();
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            idle();
            if (c < 32) set_rd(0, c);
            #1;
            if (c < 32) check("t3_cmd_ready", 128'(rd_cmd_ready[0]), 128'd1);
            if (c >= 2 && c < 34) begin
                check("t3_valid", 128'(rd_resp_valid[0]), 128'd1);
                check("t3_data", rd_resp_data[127:0], mk0(c - 2));
            end else begin
                check("t3_idle", 128'(rd_resp_valid[0]), 128'd0);
            end
        end

        // Test 4: same stream with random backpressure
        sent = 0;
        rcv  = 0;
        held = 1'b0;
        held_data = '0;
        cyc  = 0;
        while (rcv < 32 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            idle();
            rd_resp_ready[0] = 1'($urandom_range(0, 1));
            if (sent < 32) set_rd(0, sent);
            #1;
            in_flight = sent - rcv;
            exp_ready = !(in_flight == 2 && !rd_resp_ready[0]);
            if (held) begin
                check("t4_hold_valid", 128'(rd_resp_valid[0]), 128'd1);
                check("t4_hold_data", rd_resp_data[127:0], held_data);
            end
            check("t4_cmd_ready", 128'(rd_cmd_ready[0]), 128'(exp_ready));
            if (rd_resp_valid[0] && rd_resp_ready[0]) begin
                check("t4_data", rd_resp_data[127:0], mk0(rcv));
                rcv++;
            end
            if (rd_cmd_valid[0] && rd_cmd_ready[0]) sent++;
            held      = rd_resp_valid[0] && !rd_resp_ready[0];
            held_data = rd_resp_data[127:0];
        end
        check("t4_count", 128'(rcv), 128'd32);
        @(negedge clk);
        idle();
        rd_resp_ready = 2'b11;
        repeat (3) @(negedge clk);
        check("t4_drained", 128'(rd_resp_valid), 128'd0);

        // Test 5: same-edge read/write collision on seg0, independent seg1 traffic
        @(negedge clk);
        idle();
        set_wr(0, 7, {16{8'h11}}, 16'hFFFF);
        @(negedge clk);
        idle();
        set_wr(0, 7, {16{8'h22}}, 16'hFFFF);
        set_rd(0, 7);
        set_wr(1, 20, mk1(20), 16'hFFFF);
        set_rd(1, 2);
        @(negedge clk);
        idle();
        check("t5_early", 128'(rd_resp_valid), 128'd0);
        @(negedge clk);
        check("t5_valid", 128'(rd_resp_valid), 128'd3);
        check("t5_old", rd_resp_data[127:0], {16{8'h11}});
        check("t5_seg1", rd_resp_data[255:128], mk1(2));
        read_chk(0, 7, {16{8'h22}}, "t5_new");
        read_chk(1, 20, mk1(20), "t5_seg1_wr");

        // Test 6: reset with two reads in flight and a write accepted
        @(negedge clk);
        idle();
        set_rd(0, 0);
        @(negedge clk);
        idle();
        set_rd(0, 1);
        @(negedge clk);
        idle();
        rst = 1'b1;
        set_wr(0, 40, 128'hDEADBEEF_01234567_89ABCDEF_C0FFEE00, 16'hFFFF);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        check("t6_resp_valid", 128'(rd_resp_valid), 128'd0);
        check("t6_wr_done", 128'(wr_done), 128'd0);
        check("t6_cmd_ready", 128'(rd_cmd_ready), 128'd3);
        read_chk(0, 40, 128'hDEADBEEF_01234567_89ABCDEF_C0FFEE00, "t6_rst_write");
        read_chk(0, 1, mk0(1), "t6_post_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
